// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the fetch-side branch predictor.
//   - bhtCnt_e   : 2-bit saturating direction counter encodings.
//   - BHT_RESET  : value every BHT counter takes on reset.
//   - btbEntry_t : one BTB entry (valid, tag, target, jump).
//   - satUpdate  : saturating counter step towards taken/not-taken.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bhtCnt_e;

  localparam bhtCnt_e BHT_RESET = WNT;

  // Tag is sized for the smallest legal index (PC[31:2]); narrower tags are
  // zero-extended, so the struct stays independent of the BTB depth.
  localparam int BTB_TAG_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 jump;
  } btbEntry_t;

  function automatic bhtCnt_e satUpdate(input bhtCnt_e cnt, input logic up);
    bhtCnt_e res;
    case (cnt)
      SNT:     res = up ? WNT : SNT;
      WNT:     res = up ? WT  : SNT;
      WT:      res = up ? ST  : WNT;
      ST:      res = up ? ST  : WT;
      default: res = BHT_RESET;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_fetch_unit_btb.sv
// bp_btb: direct-mapped branch target buffer.
//   clk, rst      : clock, async active-high reset (clears valid bits only).
//   rdIdx/rdEntry : combinational read port (pre-edge contents).
//   wrEn/wrIdx/wrEntry : synchronous write port, unconditional replace.
module bp_btb
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdx,
  output btbEntry_t        rdEntry,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  btbEntry_t        wrEntry
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]     valid_r;
  logic [BTB_TAG_W-1:0] tag_r    [DEPTH];
  logic [31:0]          target_r [DEPTH];
  logic [DEPTH-1:0]     jump_r;

  // Valid bits: only state that needs clearing on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wrEn) begin
      valid_r[wrIdx] <= wrEntry.valid;
    end
  end

  // Payload storage: qualified by valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tag_r[wrIdx]    <= wrEntry.tag;
      target_r[wrIdx] <= wrEntry.target;
      jump_r[wrIdx]   <= wrEntry.jump;
    end
  end

  // Combinational read: a same-cycle write is not forwarded.
  always_comb begin
    rdEntry.valid  = valid_r[rdIdx];
    rdEntry.tag    = tag_r[rdIdx];
    rdEntry.target = target_r[rdIdx];
    rdEntry.jump   = jump_r[rdIdx];
  end

endmodule

// File: rtl/bp_fetch_unit.sv
// bp_fetch_unit: PC generation with 2-bit BHT + direct-mapped BTB prediction.
//   clk, rst        : clock, async active-high reset.
//   StallF          : hold PCF (a mispredict redirect wins over it).
//   PCF, PCPlus4F   : fetch PC and its sequential successor.
//   PredTakenF/PredTargetF : zero-latency prediction for PCF.
//   BranchE, JumpE, PCSrcE, PCTargetE, PCE, PredTakenE, PredTargetE :
//                     branch resolution from execute.
//   MispredictE, FlushD, FlushE : combinational mispredict / flush.
//   MispredCount    : wrapping count of mispredictions.
module bp_fetch_unit
  import bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 6,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] PCE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] MispredCount
);

  localparam int BHT_DEPTH = 1 << BHT_IDX_W;

  bhtCnt_e              bht_r [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] bhtIdxF_s, bhtIdxE_s;
  logic [BTB_IDX_W-1:0] btbIdxF_s, btbIdxE_s;
  logic [BTB_TAG_W-1:0] tagF_s, tagE_s;
  btbEntry_t            rdEntry_s, wrEntry_s;
  logic                 btbHit_s, bhtTaken_s, resolveE_s, btbWrEn_s;
  logic [31:0]          redirectPc_s, nextPc_s;

  assign bhtIdxF_s = PCF[BHT_IDX_W+1:2];
  assign bhtIdxE_s = PCE[BHT_IDX_W+1:2];
  assign btbIdxF_s = PCF[BTB_IDX_W+1:2];
  assign btbIdxE_s = PCE[BTB_IDX_W+1:2];
  // Tag = PC[31:BTB_IDX_W+2], zero-extended to the struct tag width.
  assign tagF_s    = PCF[31:2] >> BTB_IDX_W;
  assign tagE_s    = PCE[31:2] >> BTB_IDX_W;

  bp_btb #(.IDX_W(BTB_IDX_W)) u_btb (
    .clk     (clk),
    .rst     (rst),
    .rdIdx   (btbIdxF_s),
    .rdEntry (rdEntry_s),
    .wrEn    (btbWrEn_s),
    .wrIdx   (btbIdxE_s),
    .wrEntry (wrEntry_s)
  );

  // Fetch-side lookup.
  assign PCPlus4F    = PCF + 32'd4;
  assign btbHit_s    = rdEntry_s.valid && (rdEntry_s.tag == tagF_s);
  assign bhtTaken_s  = (bht_r[bhtIdxF_s] == WT) || (bht_r[bhtIdxF_s] == ST);
  assign PredTakenF  = btbHit_s && (rdEntry_s.jump || bhtTaken_s);
  assign PredTargetF = PredTakenF ? rdEntry_s.target : PCPlus4F;

  // Execute-side resolution: wrong direction, or taken with wrong target.
  assign resolveE_s   = BranchE | JumpE;
  assign MispredictE  = resolveE_s &&
                        ((PCSrcE != PredTakenE) ||
                         (PCSrcE && PredTakenE && (PCTargetE != PredTargetE)));
  assign FlushD       = MispredictE;
  assign FlushE       = MispredictE;
  assign redirectPc_s = PCSrcE ? PCTargetE : (PCE + 32'd4);

  // BTB only learns taken outcomes.
  assign btbWrEn_s = resolveE_s && PCSrcE;
  always_comb begin
    wrEntry_s.valid  = 1'b1;
    wrEntry_s.tag    = tagE_s;
    wrEntry_s.target = PCTargetE;
    wrEntry_s.jump   = JumpE;
  end

  // Next-PC priority: redirect, stall, predicted target, sequential.
  always_comb begin
    nextPc_s = PCPlus4F;
    if (MispredictE) begin
      nextPc_s = redirectPc_s;
    end else if (StallF) begin
      nextPc_s = PCF;
    end else if (PredTakenF) begin
      nextPc_s = PredTargetF;
    end else begin
      nextPc_s = PCPlus4F;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= nextPc_s;
    end
  end

  // BHT training: conditional branches only, independent of StallF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= BHT_RESET;
      end
    end else if (BranchE && !JumpE) begin
      bht_r[bhtIdxE_s] <= satUpdate(bht_r[bhtIdxE_s], PCSrcE);
    end
  end

  // Misprediction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MispredCount <= 32'd0;
    end else if (MispredictE) begin
      MispredCount <= MispredCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_bp_fetch_unit.sv
// tb_bp_fetch_unit: directed-vector bench for bp_fetch_unit.
module tb_bp_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic [31:0] PCF, PCPlus4F, PredTargetF, PCTargetE, PCE, PredTargetE;
  logic        PredTakenF, BranchE, JumpE, PCSrcE, PredTakenE;
  logic        MispredictE, FlushD, FlushE;
  logic [31:0] MispredCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] expCount;

  bp_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .StallF       (StallF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .PredTakenF   (PredTakenF),
    .PredTargetF  (PredTargetF),
    .BranchE      (BranchE),
    .JumpE        (JumpE),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .PCE          (PCE),
    .PredTakenE   (PredTakenE),
    .PredTargetE  (PredTargetE),
    .MispredictE  (MispredictE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .MispredCount (MispredCount)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    StallF = 1'b0; BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'd0; PCE = 32'd0; PredTakenE = 1'b0; PredTargetE = 32'd0;
  endtask

  task automatic drive(input logic br, input logic jmp, input logic src,
                       input logic [31:0] pce, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt, input logic stall);
    BranchE = br; JumpE = jmp; PCSrcE = src; PCE = pce; PCTargetE = tgt;
    PredTakenE = pt; PredTargetE = ptgt; StallF = stall;
  endtask

  // Advance one cycle; afterwards we sit 1ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Redirect fetch to pc via a not-taken branch at pc-4 that was predicted taken.
  task automatic redirectTo(input logic [31:0] pc);
    drive(1'b1, 1'b0, 1'b0, pc - 32'd4, 32'd0, 1'b1, 32'hDEAD_0000, 1'b0);
    #1 checkVal("redir_mispred", {31'd0, MispredictE}, 32'd1);
    step();
    expCount = expCount + 32'd1;
    idle();
    checkVal("redir_pcf", PCF, pc);
  endtask

  initial begin
    idle();
    expCount = 32'd0;
    rst = 1'b1;
    #1;
    checkVal("rst_pcf", PCF, 32'h0);
    checkVal("rst_predtaken", {31'd0, PredTakenF}, 32'd0);
    checkVal("rst_count", MispredCount, 32'd0);
    step();
    rst = 1'b0;
    checkVal("run_pc0", PCF, 32'h0);
    checkVal("run_target0", PredTargetF, 32'h4);
    step(); checkVal("run_pc4", PCF, 32'h4);
    step(); checkVal("run_pc8", PCF, 32'h8);

    // Branch 0x10 taken to 0x40, predicted not-taken.
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h0, 1'b0);
    #1;
    checkVal("mp1_mispred", {31'd0, MispredictE}, 32'd1);
    checkVal("mp1_flushd", {31'd0, FlushD}, 32'd1);
    checkVal("mp1_flushe", {31'd0, FlushE}, 32'd1);
    step(); expCount = expCount + 32'd1; idle();
    checkVal("mp1_pcf", PCF, 32'h40);
    checkVal("mp1_count", MispredCount, 32'd1);

    // Refetch 0x10: BTB hit, BHT now WT.
    redirectTo(32'h10);
    checkVal("bht_wt_taken", {31'd0, PredTakenF}, 32'd1);
    checkVal("bht_wt_target", PredTargetF, 32'h40);

    // Three correctly predicted taken resolves while stalled: counter to ST.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40, 1'b1);
      #1 checkVal("train_nomp", {31'd0, MispredictE}, 32'd0);
      step(); idle();
      checkVal("stall_hold", PCF, 32'h10);
    end

    // Not-taken while predicted taken, with StallF high: redirect wins.
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40, 1'b1);
    #1 checkVal("nt_mispred", {31'd0, MispredictE}, 32'd1);
    step(); expCount = expCount + 32'd1; idle();
    checkVal("nt_redirect", PCF, 32'h14);
    checkVal("nt_count", MispredCount, expCount);

    // ST -> WT: 0x10 still predicted taken.
    redirectTo(32'h10);
    checkVal("st_to_wt_taken", {31'd0, PredTakenF}, 32'd1);

    // Same-index lookup and update: pre-edge prediction, then WT -> WNT.
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    checkVal("sameidx_nomp", {31'd0, MispredictE}, 32'd0);
    checkVal("sameidx_pre", {31'd0, PredTakenF}, 32'd1);
    step(); idle(); StallF = 1'b1; #1;
    checkVal("sameidx_post", {31'd0, PredTakenF}, 32'd0);
    checkVal("sameidx_tgt", PredTargetF, 32'h14);
    StallF = 1'b0;

    // jal at 0x20 -> 0x100, unpredicted.
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h100, 1'b0, 32'h0, 1'b0);
    #1 checkVal("jal_mispred", {31'd0, MispredictE}, 32'd1);
    step(); expCount = expCount + 32'd1; idle();
    checkVal("jal_pcf", PCF, 32'h100);

    // Jump bit forces taken even though BHT[0x20] is WNT.
    redirectTo(32'h20);
    checkVal("jal_pred", {31'd0, PredTakenF}, 32'd1);
    checkVal("jal_predtgt", PredTargetF, 32'h100);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h100, 1'b1, 32'h100, 1'b0);
    #1 checkVal("jal_correct", {31'd0, MispredictE}, 32'd0);
    step(); idle();
    checkVal("jal_follow", PCF, 32'h100);

    // Right direction, wrong target.
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h40, 1'b0);
    #1 checkVal("tgt_mispred", {31'd0, MispredictE}, 32'd1);
    step(); expCount = expCount + 32'd1; idle();
    checkVal("tgt_pcf", PCF, 32'h80);

    // 0x50 shares BTB index with 0x10 but a different tag: miss.
    redirectTo(32'h50);
    checkVal("alias_miss", {31'd0, PredTakenF}, 32'd0);
    checkVal("alias_tgt", PredTargetF, 32'h54);
    checkVal("count_total", MispredCount, expCount);

    // Mid-run reset clears PC, counter and all training.
    #1 rst = 1'b1;
    #1;
    checkVal("mrst_pcf", PCF, 32'h0);
    checkVal("mrst_count", MispredCount, 32'd0);
    checkVal("mrst_pred", {31'd0, PredTakenF}, 32'd0);
    rst = 1'b0;
    expCount = 32'd0;
    step();
    redirectTo(32'h10);
    checkVal("mrst_btb_inv", {31'd0, PredTakenF}, 32'd0);
    redirectTo(32'h20);
    checkVal("mrst_btb_inv2", {31'd0, PredTakenF}, 32'd0);
    checkVal("mrst_count2", MispredCount, expCount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fetch_unit.md
Name: bp_fetch_unit

Overview:
- Fetch-side branch prediction and PC generation unit.
- Consumes branch resolution from the execute stage: actual taken flag, resolved target, branch/jump qualifiers, and the prediction carried down the pipe.
- Produces PCF plus the prediction for each fetched instruction, trains a 2-bit BHT and a direct-mapped BTB, and raises pipeline flushes on misprediction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_IDX_W, 6, BHT index width; 64 entries, index = PC[BHT_IDX_W+1:2].
- BTB_IDX_W, 4, BTB index width; 16 entries, index = PC[BTB_IDX_W+1:2], tag = PC[31:BTB_IDX_W+2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- StallF  in  1  hold PCF; ignored during a mispredict redirect.
- PCF  out  32  current fetch PC.
- PCPlus4F  out  32  PCF+4.
- PredTakenF  out  1  prediction for the instruction at PCF.
- PredTargetF  out  32  predicted target; PCF+4 when PredTakenF=0.
- BranchE  in  1  instruction in execute is a conditional branch.
- JumpE  in  1  instruction in execute is jal/jalr.
- PCSrcE  in  1  actual taken, from execute.
- PCTargetE  in  32  resolved target, from execute.
- PCE  in  32  PC of the instruction in execute.
- PredTakenE  in  1  PredTakenF carried to execute.
- PredTargetE  in  32  PredTargetF carried to execute.
- MispredictE  out  1  combinational misprediction flag.
- FlushD  out  1  equals MispredictE.
- FlushE  out  1  equals MispredictE.
- MispredCount  out  32  count of mispredictions; wraps.

Behaviour:
- Reset (async), all forced immediately:
  - PCF=RESET_PC.
  - All BHT counters=2'b01 (weakly not-taken).
  - All BTB valid=0.
  - MispredCount=0.
- Reset mid-operation discards all training state; the first fetch after reset is RESET_PC with PredTakenF=0.
- Lookup is combinational on PCF, zero-cycle latency. BTB hit = valid && tag match.
  - PredTakenF = hit && (jump bit || BHT[idx][1]).
  - PredTargetF = hit target when PredTakenF, else PCPlus4F.
- Resolve valid: ResolveE = BranchE | JumpE.
- Mispredict: MispredictE = ResolveE && ((PCSrcE != PredTakenE) || (PCSrcE && PredTakenE && PCTargetE != PredTargetE)).
- Redirect PC = PCSrcE ? PCTargetE : PCE+4.
- Next PC, highest priority first:
  1. MispredictE → redirect PC (overrides StallF).
  2. StallF → hold.
  3. PredTakenF → PredTargetF.
  4. Otherwise → PCPlus4F.
- Training happens at the clock edge when ResolveE:
  - BranchE: BHT[PCE idx] saturating increment if PCSrcE, decrement otherwise. 11 stays 11; 00 stays 00.
  - PCSrcE=1: BTB[PCE idx] is written with valid=1, tag, target=PCTargetE, jump bit=JumpE. Existing entries are replaced unconditionally.
  - PCSrcE=0: the BTB is not modified.
  - JumpE: no BHT update.
- Simultaneous lookup and update to the same index: the lookup uses pre-edge contents (no write-through).
- Training is not gated by StallF. Resolved information is always committed.
- MispredCount increments by 1 on each clock edge with MispredictE=1. 32'hFFFF_FFFF+1 wraps to 0.
- Non-word-aligned PCTargetE is stored as-is; alignment faults are out of scope.

Decomposition:
- Shared package bp_pkg holds:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - BHT reset value WNT.
  - BTB entry struct: valid, tag, target, jump.
- One natural sub-module: bp_btb (direct-mapped storage, combinational read, synchronous write, async valid clear). BHT and PC logic stay in bp_fetch_unit.

Test Plan:
- Reset → PCF=0, PredTakenF=0, MispredCount=0. Free-run 3 cycles → PCF=0,4,8.
- Branch at PCE=0x10 resolved taken, PCTargetE=0x40, PredTakenE=0:
  - Same cycle: MispredictE=FlushD=FlushE=1; next PCF=0x40; MispredCount=1.
  - BTB[0x10] valid. BHT still 10 (WT) after one increment, so a refetch of 0x10 gives PredTakenF=1, PredTargetF=0x40.
- Branch 0x10 resolved taken 3 more times → counter saturates at 11. Then resolved not-taken with PredTakenE=1, PredTargetE=0x40:
  - Mispredict; next PCF=0x14.
  - Counter=10; PredTakenF at 0x10 is still 1.
- jal at PCE=0x20, PCSrcE=1, target 0x100:
  - BTB jump bit set; later fetch of 0x20 gives PredTakenF=1 regardless of BHT.
  - Correct prediction with matching target → MispredictE=0.
- Correct direction, wrong target (PredTargetE=0x40, PCTargetE=0x80) → MispredictE=1, next PCF=0x80.
- StallF=1 with MispredictE=1 → PCF takes the redirect. StallF=1 alone → PCF held.
- Assert rst mid-run → PCF=RESET_PC immediately, all BTB entries invalid.
